apb_uart_fifo: RTL and testbench
================================

// Module: apb_uart_fifo
// PURPOSE
//  Next-generation APB3 UART peripheral with parametrised TX/RX FIFOs, 16x-oversampled receiver,
//  programmable baud divisor, sticky error flags and a maskable interrupt. Sits on the fabric APB
//  bus as a CPU console/debug port; serial pins go straight to top-level IO.
// PARAMETERS
//  FIFO_DEPTH   16  entries per FIFO; power of 2, 2..256
//  BAUD_WIDTH   16  width of baud divisor; oversample tick every (BAUD+1) PCLK cycles
//  RST_BAUD     0   reset value of BAUD register
// PORTS
//  PCLK     in   1   system clock
//  PRESET   in   1   reset, synchronous, active-high
//  PADDR    in   5   byte address; [4:2] selects register
//  PSEL     in   1   APB select
//  PENABLE  in   1   APB access phase
//  PWRITE   in   1   1 = write
//  PWDATA   in   32  write data
//  PRDATA   out  32  read data, valid in access phase
//  PREADY   out  1   tied 1 (zero wait states)
//  PSLVERR  out  1   1 on access to PADDR[4:2] 6 or 7, else 0
//  RX       in   1   serial in (asynchronous)
//  TX       out  1   serial out, idle high
//  IRQ      out  1   registered interrupt
// BEHAVIOUR
//  Reset: TX=1, IRQ=0, PRDATA=0, all regs 0 except BAUD=RST_BAUD; FIFOs flushed; FSMs IDLE.
//  Access = PSEL&PENABLE. Registers (PADDR[4:2]):
//   0 DATA  W: push TX FIFO; if full drop, set TX_OVF. R: RX head, pop; if empty read 0, no pop.
//   1 STAT  R:[0]tx_full [1]tx_empty [2]rx_empty [3]rx_full [4]rx_ovf [5]frame_err [6]parity_err
//           [7]tx_ovf [8]tx_busy. W1C on bits 4..7; set-and-clear same cycle -> stays set.
//   2 CTRL  RW:[0]parity_en [1]odd [2]tx_en [3]rx_en
//   3 BAUD  RW:[BAUD_WIDTH-1:0]; takes effect at next divider reload, never mid-count.
//   4 IEN   RW:[0]rx_not_empty [1]tx_empty [2]any sticky error
//   5 LVL   R:[8:0]tx_count [24:16]rx_count
//  Unused read bits return 0. PRDATA combinational from registers/FIFO head during access phase.
//  IRQ <= |(IEN & {err, tx_empty, ~rx_empty}) ; one-cycle latency.
//  Divider: counter 0..BAUD, tick on reaching BAUD; BAUD=0 -> tick every cycle.
//  TX FSM IDLE->START->DATA(8, LSB first)->[PARITY]->STOP->IDLE; each bit 16 ticks.
//   Leaves IDLE when tx_en & ~tx_empty, popping FIFO on that cycle. tx_en cleared mid-frame:
//   frame completes. Back-to-back frames: STOP->START directly if FIFO non-empty.
//  RX: RX 2-flop synchronised. FSM IDLE->START->DATA->[PARITY]->STOP. Falling edge in IDLE
//   (rx_en=1) starts; line re-sampled at tick 7: if high -> IDLE (glitch). Bits sampled at
//   mid-bit (every 16 ticks). Stop=0: set frame_err, byte discarded. Parity mismatch: set
//   parity_err, byte pushed. Push while full: byte discarded, rx_ovf set.
//  FIFO: simultaneous push+pop when full -> both succeed; when empty -> push only. Pointers
//   wrap modulo FIFO_DEPTH; count is log2(DEPTH)+1 bits.
//  Reset mid-frame: TX high on next edge, partial RX byte discarded.
// STRUCTURE
//  Package apb_uart_pkg: register offsets, STAT/CTRL/IEN bit indices, tx/rx state enums.
//  Sub-module uart_sync_fifo (WIDTH, DEPTH): push/pop/full/empty/count/head; instantiated twice.
//  TX FSM, RX FSM, divider and APB decode inline in top.
// TESTING
//  BAUD=0, CTRL=0x4, write DATA=0xA5 -> TX: start, bits 1,0,1,0,0,1,0,1, stop; 16 PCLK/bit.
//  Loopback TX->RX, parity_en odd, 20 bytes, DEPTH=16 -> 16 read back in order, rx_ovf=1, LVL=16.
//  RX frame with stop=0 -> frame_err=1, rx_empty stays 1; W1C 0x20 to STAT clears it.
//  1-tick low glitch on RX -> no push, RX FSM back to IDLE.
//  IEN=0x1, byte received -> IRQ rises 1 cycle after push; DATA read empties -> IRQ falls.
//  PRESET asserted mid-TX-frame -> TX=1 next edge, LVL=0, STAT=0x0006.

Source files
------------

// File: rtl/apb_uart_pkg.sv
// Shared definitions for the APB UART: register map, status/control
// bit positions, TX/RX state encodings and a parity helper.
package apb_uart_pkg;

    localparam logic [2:0] REG_DATA = 3'd0;
    localparam logic [2:0] REG_STAT = 3'd1;
    localparam logic [2:0] REG_CTRL = 3'd2;
    localparam logic [2:0] REG_BAUD = 3'd3;
    localparam logic [2:0] REG_IEN  = 3'd4;
    localparam logic [2:0] REG_LVL  = 3'd5;

    localparam int ST_TX_FULL  = 0;
    localparam int ST_TX_EMPTY = 1;
    localparam int ST_RX_EMPTY = 2;
    localparam int ST_RX_FULL  = 3;
    localparam int ST_RX_OVF   = 4;
    localparam int ST_FRAME    = 5;
    localparam int ST_PARITY   = 6;
    localparam int ST_TX_OVF   = 7;
    localparam int ST_TX_BUSY  = 8;

    localparam int CT_PAR_EN = 0;
    localparam int CT_ODD    = 1;
    localparam int CT_TX_EN  = 2;
    localparam int CT_RX_EN  = 3;

    localparam int IE_RXNE = 0;
    localparam int IE_TXE  = 1;
    localparam int IE_ERR  = 2;

    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
    } rx_state_t;

    // Parity bit to transmit: even parity when odd=0, odd parity when odd=1.
    function automatic logic parity_bit(input logic [7:0] d, input logic odd);
        return (^d) ^ odd;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with registered pointers and an occupancy count.
// Ports: clk/rst, push+din, pop, head (current entry), full, empty, count.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] ONE = 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    // A pop frees a slot in the same cycle, so push into a full FIFO
    // still succeeds when it coincides with a pop.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign head    = mem[rptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + ONE;
            if (do_pop)  rptr <= rptr + ONE;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= din;
    end

endmodule

// File: rtl/apb_uart_fifo.sv
// APB3 UART with TX/RX FIFOs, 16x oversampling, sticky errors and IRQ.
// Ports: APB3 slave (PCLK, PRESET sync high), serial RX/TX, registered IRQ.
module apb_uart_fifo
    import apb_uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int BAUD_WIDTH = 16,
    parameter logic [BAUD_WIDTH-1:0] RST_BAUD = '0
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic [4:0]  PADDR,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    input  logic        RX,
    output logic        TX,
    output logic        IRQ
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [3:0]            ctrl;
    logic [BAUD_WIDTH-1:0] baud;
    logic [2:0]            ien;
    // {tx_ovf, parity_err, frame_err, rx_ovf} = STAT[7:4]
    logic [3:0]            sticky;

    logic       acc, wr, rd;
    logic [2:0] ra;
    logic       unused_ok;

    assign acc = PSEL & PENABLE;
    assign wr  = acc & PWRITE;
    assign rd  = acc & ~PWRITE;
    assign ra  = PADDR[4:2];
    assign PREADY  = 1'b1;
    assign PSLVERR = acc & (ra[2:1] == 2'b11);
    assign unused_ok = ^{PADDR[1:0], PWDATA};

    logic          tx_push, tx_pop, tx_full, tx_empty;
    logic [7:0]    tx_head;
    logic [CW-1:0] tx_cnt;
    logic          rx_push, rx_pop, rx_full, rx_empty;
    logic [7:0]    rx_head;
    logic [CW-1:0] rx_cnt;
    logic [7:0]    rx_sh;

    assign tx_push = wr & (ra == REG_DATA);
    assign rx_pop  = rd & (ra == REG_DATA);

    uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(PCLK), .rst(PRESET), .push(tx_push), .din(PWDATA[7:0]),
        .pop(tx_pop), .head(tx_head), .full(tx_full),
        .empty(tx_empty), .count(tx_cnt)
    );

    uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(PCLK), .rst(PRESET), .push(rx_push), .din(rx_sh),
        .pop(rx_pop), .head(rx_head), .full(rx_full),
        .empty(rx_empty), .count(rx_cnt)
    );

    // Baud divider; the limit is reloaded only at wrap so a BAUD write
    // never shortens or stretches the count in progress.
    logic [BAUD_WIDTH-1:0] div_cnt, div_lim;
    logic                  tick;
    assign tick = (div_cnt == div_lim);

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            div_cnt <= '0;
            div_lim <= RST_BAUD;
        end else if (tick) begin
            div_cnt <= '0;
            div_lim <= baud;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Transmitter
    tx_state_t  tx_st;
    logic [3:0] tx_tcnt;
    logic [2:0] tx_bit;
    logic [7:0] tx_sh;
    logic       tx_par, tx_pen, tx_q, tx_bit_end;

    assign tx_bit_end = tick & (tx_tcnt == 4'd15);
    assign tx_pop = ((tx_st == TX_IDLE) | ((tx_st == TX_STOP) & tx_bit_end))
                    & ctrl[CT_TX_EN] & ~tx_empty;
    assign TX = tx_q;

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            tx_st   <= TX_IDLE;
            tx_q    <= 1'b1;
            tx_tcnt <= '0;
            tx_bit  <= '0;
            tx_sh   <= '0;
            tx_par  <= 1'b0;
            tx_pen  <= 1'b0;
        end else if (tx_pop) begin
            tx_st   <= TX_START;
            tx_q    <= 1'b0;
            tx_tcnt <= '0;
            tx_bit  <= '0;
            tx_sh   <= tx_head;
            tx_par  <= parity_bit(tx_head, ctrl[CT_ODD]);
            tx_pen  <= ctrl[CT_PAR_EN];
        end else begin
            // 4-bit tick counter wraps to 0 at each bit boundary
            if (tick && tx_st != TX_IDLE) tx_tcnt <= tx_tcnt + 4'd1;
            unique case (tx_st)
                TX_IDLE: ;
                TX_START: if (tx_bit_end) begin
                    tx_st <= TX_DATA;
                    tx_q  <= tx_sh[0];
                end
                TX_DATA: if (tx_bit_end) begin
                    if (tx_bit == 3'd7) begin
                        tx_st <= tx_pen ? TX_PARITY : TX_STOP;
                        tx_q  <= tx_pen ? tx_par : 1'b1;
                    end else begin
                        tx_bit <= tx_bit + 3'd1;
                        tx_sh  <= tx_sh >> 1;
                        tx_q   <= tx_sh[1];
                    end
                end
                TX_PARITY: if (tx_bit_end) begin
                    tx_st <= TX_STOP;
                    tx_q  <= 1'b1;
                end
                TX_STOP: if (tx_bit_end) tx_st <= TX_IDLE;
                default: tx_st <= TX_IDLE;
            endcase
        end
    end

    // Receiver
    logic       rx_s1, rx_s2, rx_d, rx_fall;
    rx_state_t  rx_st;
    logic [3:0] rx_tcnt;
    logic [2:0] rx_bit;
    logic       rx_pen, rx_odd, rx_bit_end;
    logic       rx_ovf_set, frame_set, par_set, tx_ovf_set;

    assign rx_fall    = rx_d & ~rx_s2;
    assign rx_bit_end = tick & (rx_tcnt == 4'd15);
    assign rx_push    = (rx_st == RX_STOP) & rx_bit_end & rx_s2;
    assign frame_set  = (rx_st == RX_STOP) & rx_bit_end & ~rx_s2;
    assign par_set    = (rx_st == RX_PARITY) & rx_bit_end
                        & (parity_bit(rx_sh, rx_odd) != rx_s2);
    assign rx_ovf_set = rx_push & rx_full & ~rx_pop;
    assign tx_ovf_set = tx_push & tx_full & ~tx_pop;

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_d  <= 1'b1;
        end else begin
            rx_s1 <= RX;
            rx_s2 <= rx_s1;
            rx_d  <= rx_s2;
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            rx_st   <= RX_IDLE;
            rx_tcnt <= '0;
            rx_bit  <= '0;
            rx_sh   <= '0;
            rx_pen  <= 1'b0;
            rx_odd  <= 1'b0;
        end else begin
            unique case (rx_st)
                RX_IDLE: if (ctrl[CT_RX_EN] & rx_fall) begin
                    rx_st   <= RX_START;
                    rx_tcnt <= '0;
                    rx_bit  <= '0;
                    rx_pen  <= ctrl[CT_PAR_EN];
                    rx_odd  <= ctrl[CT_ODD];
                end
                // Mid start bit: a line already high again was a glitch
                RX_START: if (tick) begin
                    if (rx_tcnt == 4'd7) begin
                        rx_st   <= rx_s2 ? RX_IDLE : RX_DATA;
                        rx_tcnt <= '0;
                    end else begin
                        rx_tcnt <= rx_tcnt + 4'd1;
                    end
                end
                RX_DATA: begin
                    if (tick) rx_tcnt <= rx_tcnt + 4'd1;
                    if (rx_bit_end) begin
                        rx_sh <= {rx_s2, rx_sh[7:1]};
                        if (rx_bit == 3'd7)
                            rx_st <= rx_pen ? RX_PARITY : RX_STOP;
                        else
                            rx_bit <= rx_bit + 3'd1;
                    end
                end
                RX_PARITY: begin
                    if (tick) rx_tcnt <= rx_tcnt + 4'd1;
                    if (rx_bit_end) rx_st <= RX_STOP;
                end
                RX_STOP: begin
                    if (tick) rx_tcnt <= rx_tcnt + 4'd1;
                    if (rx_bit_end) rx_st <= RX_IDLE;
                end
                default: rx_st <= RX_IDLE;
            endcase
        end
    end

    // Registers, W1C sticky flags (a new event wins over a clear) and IRQ
    logic [3:0] st_clr;
    assign st_clr = (wr && ra == REG_STAT) ? PWDATA[7:4] : 4'b0;

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            ctrl   <= '0;
            baud   <= RST_BAUD;
            ien    <= '0;
            sticky <= '0;
            IRQ    <= 1'b0;
        end else begin
            sticky <= (sticky & ~st_clr)
                      | {tx_ovf_set, par_set, frame_set, rx_ovf_set};
            IRQ <= |(ien & {|sticky, tx_empty, ~rx_empty});
            if (wr) begin
                unique case (1'b1)
                    ra == REG_CTRL: ctrl <= PWDATA[3:0];
                    ra == REG_BAUD: baud <= PWDATA[BAUD_WIDTH-1:0];
                    ra == REG_IEN:  ien  <= PWDATA[2:0];
                    default: ;
                endcase
            end
        end
    end

    logic [8:0] stat_w;
    assign stat_w = {tx_st != TX_IDLE, sticky,
                     rx_full, rx_empty, tx_empty, tx_full};

    always_comb begin
        PRDATA = '0;
        if (rd) begin
            unique case (1'b1)
                ra == REG_DATA: PRDATA = rx_empty ? 32'd0 : {24'd0, rx_head};
                ra == REG_STAT: PRDATA = {23'd0, stat_w};
                ra == REG_CTRL: PRDATA = {28'd0, ctrl};
                ra == REG_BAUD: PRDATA = 32'(baud);
                ra == REG_IEN:  PRDATA = {29'd0, ien};
                ra == REG_LVL:  PRDATA = {7'd0, 9'(rx_cnt), 7'd0, 9'(tx_cnt)};
                default:        PRDATA = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_uart_fifo.sv
// Directed self-checking bench for apb_uart_fifo.
// Expected RX bytes are queued when driven and compared when read out.
module tb_apb_uart_fifo;

    localparam int DEPTH = 16;
    localparam logic [4:0] A_DATA = 5'h00;
    localparam logic [4:0] A_STAT = 5'h04;
    localparam logic [4:0] A_CTRL = 5'h08;
    localparam logic [4:0] A_BAUD = 5'h0C;
    localparam logic [4:0] A_IEN  = 5'h10;
    localparam logic [4:0] A_LVL  = 5'h14;
    localparam logic [4:0] A_BAD  = 5'h18;

    logic        PCLK = 1'b0;
    logic        PRESET = 1'b1;
    logic [4:0]  PADDR = '0;
    logic        PSEL = 1'b0;
    logic        PENABLE = 1'b0;
    logic        PWRITE = 1'b0;
    logic [31:0] PWDATA = '0;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic        RX;
    logic        TX;
    logic        IRQ;
    logic        rx_drv = 1'b1;
    logic        loop = 1'b0;

    assign RX = loop ? TX : rx_drv;

    apb_uart_fifo #(.FIFO_DEPTH(DEPTH), .BAUD_WIDTH(16), .RST_BAUD(16'd0)) dut (
        .PCLK(PCLK), .PRESET(PRESET), .PADDR(PADDR), .PSEL(PSEL),
        .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .RX(RX), .TX(TX), .IRQ(IRQ)
    );

    always #5 PCLK = ~PCLK;

    int n_cmp = 0;
    int n_mis = 0;
    logic [7:0] sb[$];

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge PCLK);
        #1;
    endtask

    task automatic apb_wr(input logic [4:0] a, input logic [31:0] d);
        @(posedge PCLK); #1;
        PSEL = 1'b1; PWRITE = 1'b1; PADDR = a; PWDATA = d; PENABLE = 1'b0;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_rd(input logic [4:0] a, output logic [31:0] d,
                          output logic err);
        @(posedge PCLK); #1;
        PSEL = 1'b1; PWRITE = 1'b0; PADDR = a; PENABLE = 1'b0;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        #2;
        d = PRDATA;
        err = PSLVERR;
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [4:0] a,
                          input logic [31:0] exp);
        logic [31:0] d;
        logic e;
        apb_rd(a, d, e);
        check(tag, d, exp);
    endtask

    task automatic wait_stat(input string tag, input logic [31:0] mask,
                             input logic [31:0] val, input int budget);
        logic [31:0] s;
        logic e;
        s = '0;
        for (int i = 0; i < budget; i++) begin
            apb_rd(A_STAT, s, e);
            if ((s & mask) == val) break;
        end
        check(tag, s & mask, val);
    endtask

    task automatic wait_tx_fall(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            cyc(1);
            if (TX === 1'b0) break;
        end
        check(tag, {31'd0, TX}, 32'd0);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit use_par,
                              input logic pbit, input logic stopb);
        rx_drv = 1'b0;
        cyc(16);
        for (int i = 0; i < 8; i++) begin
            rx_drv = d[i];
            cyc(16);
        end
        if (use_par) begin
            rx_drv = pbit;
            cyc(16);
        end
        rx_drv = stopb;
        cyc(16);
        rx_drv = 1'b1;
        cyc(4);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        logic        e;
        logic [7:0]  b;

        PRESET = 1'b1;
        cyc(4);
        check("rst_tx", {31'd0, TX}, 32'd1);
        check("rst_irq", {31'd0, IRQ}, 32'd0);
        check("rst_prdata", PRDATA, 32'd0);
        PRESET = 1'b0;
        cyc(1);
        rd_chk("rst_stat", A_STAT, 32'h6);
        rd_chk("rst_lvl", A_LVL, 32'h0);
        rd_chk("rst_ctrl", A_CTRL, 32'h0);
        rd_chk("rst_baud", A_BAUD, 32'h0);
        check("pready", {31'd0, PREADY}, 32'd1);

        apb_rd(A_BAD, d, e);
        check("slverr_bad", {31'd0, e}, 32'd1);
        check("slverr_rdata", d, 32'd0);
        apb_rd(A_CTRL, d, e);
        check("slverr_ok", {31'd0, e}, 32'd0);

        // 0xA5 frame at 16 PCLK per bit
        apb_wr(A_BAUD, 32'd0);
        apb_wr(A_CTRL, 32'h4);
        apb_wr(A_DATA, 32'hA5);
        wait_tx_fall("a5_start", 20);
        cyc(15);
        check("a5_start_end", {31'd0, TX}, 32'd0);
        cyc(1);
        check("a5_bit0_edge", {31'd0, TX}, 32'd1);
        b = 8'hA5;
        for (int i = 0; i < 8; i++) begin
            cyc(i == 0 ? 8 : 16);
            check($sformatf("a5_bit%0d", i), {31'd0, TX}, {31'd0, b[i]});
        end
        cyc(16);
        check("a5_stop", {31'd0, TX}, 32'd1);
        wait_stat("a5_idle", 32'h102, 32'h002, 50);

        // slower divider: 4 PCLK per tick, 64 per bit
        apb_wr(A_BAUD, 32'd3);
        rd_chk("baud_rd", A_BAUD, 32'd3);
        apb_wr(A_DATA, 32'h5A);
        wait_tx_fall("b3_start", 30);
        b = 8'h5A;
        for (int i = 0; i < 8; i++) begin
            cyc(i == 0 ? 96 : 64);
            check($sformatf("b3_bit%0d", i), {31'd0, TX}, {31'd0, b[i]});
        end
        wait_stat("b3_idle", 32'h102, 32'h002, 100);
        apb_wr(A_BAUD, 32'd0);

        // loopback, odd parity, 20 bytes into a 16-deep RX FIFO
        loop = 1'b1;
        apb_wr(A_CTRL, 32'hF);
        for (int i = 0; i < 20; i++) begin
            b = 8'(i * 37 + 5);
            wait_stat($sformatf("lb_room%0d", i), 32'h1, 32'h0, 200);
            apb_wr(A_DATA, {24'd0, b});
            if (i < DEPTH) sb.push_back(b);
        end
        wait_stat("lb_done", 32'h102, 32'h002, 1500);
        cyc(10);
        rd_chk("lb_lvl", A_LVL, 32'h0010_0000);
        rd_chk("lb_stat", A_STAT, 32'h1A);
        for (int i = 0; i < DEPTH; i++) begin
            apb_rd(A_DATA, d, e);
            check($sformatf("lb_data%0d", i), d, {24'd0, sb.pop_front()});
        end
        rd_chk("lb_stat_empty", A_STAT, 32'h16);
        apb_wr(A_STAT, 32'h10);
        rd_chk("lb_w1c", A_STAT, 32'h06);
        loop = 1'b0;

        // framing error: byte dropped, flag cleared by W1C
        apb_wr(A_CTRL, 32'h8);
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        rd_chk("fe_stat", A_STAT, 32'h26);
        rd_chk("fe_lvl", A_LVL, 32'h0);
        apb_wr(A_STAT, 32'h20);
        rd_chk("fe_w1c", A_STAT, 32'h06);

        // even parity, wrong parity bit: byte kept, parity_err set
        apb_wr(A_CTRL, 32'h9);
        b = 8'h81;
        send_frame(b, 1'b1, ~(^b), 1'b1);
        sb.push_back(b);
        rd_chk("pe_stat", A_STAT, 32'h42);
        apb_rd(A_DATA, d, e);
        check("pe_data", d, {24'd0, sb.pop_front()});
        apb_wr(A_STAT, 32'h40);
        rd_chk("pe_w1c", A_STAT, 32'h06);

        // rx_not_empty interrupt with a good odd-parity byte
        apb_wr(A_IEN, 32'h1);
        cyc(2);
        check("irq_idle", {31'd0, IRQ}, 32'd0);
        apb_wr(A_CTRL, 32'hB);
        b = 8'h5A;
        send_frame(b, 1'b1, ~(^b), 1'b1);
        sb.push_back(b);
        check("irq_rise", {31'd0, IRQ}, 32'd1);
        rd_chk("irq_stat", A_STAT, 32'h02);
        apb_rd(A_DATA, d, e);
        check("irq_data", d, {24'd0, sb.pop_front()});
        check("irq_hold", {31'd0, IRQ}, 32'd1);
        cyc(1);
        check("irq_fall", {31'd0, IRQ}, 32'd0);
        apb_wr(A_IEN, 32'h0);

        // one-cycle low glitch is rejected, next frame still received
        apb_wr(A_CTRL, 32'h8);
        rx_drv = 1'b0;
        cyc(1);
        rx_drv = 1'b1;
        cyc(40);
        rd_chk("gl_stat", A_STAT, 32'h06);
        rd_chk("gl_lvl", A_LVL, 32'h0);
        send_frame(8'h33, 1'b0, 1'b0, 1'b1);
        sb.push_back(8'h33);
        apb_rd(A_DATA, d, e);
        check("gl_data", d, {24'd0, sb.pop_front()});

        // reset during a TX frame
        apb_wr(A_CTRL, 32'h4);
        apb_wr(A_DATA, 32'h00);
        apb_wr(A_DATA, 32'h55);
        wait_tx_fall("rs_start", 20);
        cyc(40);
        check("rs_low", {31'd0, TX}, 32'd0);
        PRESET = 1'b1;
        cyc(1);
        check("rs_tx", {31'd0, TX}, 32'd1);
        check("rs_irq", {31'd0, IRQ}, 32'd0);
        cyc(2);
        PRESET = 1'b0;
        rd_chk("rs_lvl", A_LVL, 32'h0);
        rd_chk("rs_stat", A_STAT, 32'h6);
        rd_chk("rs_ctrl", A_CTRL, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
